zmenu_cursor_ctrl: RTL

ZMENU_CURSOR_CTRL -- requirements
Module: zmenu_cursor_ctrl

---
 rtl/zmenu_cursor_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/zmenu_cursor_ctrl.sv
// zmenu_cursor_ctrl: menu cursor with grouped items, wrap-around stepping,
// press-and-hold auto-repeat, per-group commit and cancel-to-committed.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   en                block enable; low forces reset values synchronously
//   btn_prev/next     debounced step buttons (active-high levels)
//   btn_ok/cancel     debounced commit / revert buttons
//   cursor_index      flat cursor position (group*ITEMS_PER_GROUP + item)
//   cursor_group      group under the cursor
//   cursor_item       item within that group
//   sel_value         committed item per group, group g at [g*IDX_W +: IDX_W]
//   commit_pulse      one-cycle strobe on a commit
//   commit_group      group of the last commit
module zmenu_cursor_ctrl #(
    parameter int unsigned NUM_GROUPS      = 3,
    parameter int unsigned ITEMS_PER_GROUP = 5,
    parameter int unsigned IDX_W           = 8,
    parameter bit          LABEL_ITEM0     = 1'b1,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter logic [NUM_GROUPS*IDX_W-1:0] GROUP_DEFAULTS = {8'd1, 8'd1, 8'd0}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        btn_prev,
    input  logic                        btn_next,
    input  logic                        btn_ok,
    input  logic                        btn_cancel,
    output logic [IDX_W-1:0]            cursor_index,
    output logic [IDX_W-1:0]            cursor_group,
    output logic [IDX_W-1:0]            cursor_item,
    output logic [NUM_GROUPS*IDX_W-1:0] sel_value,
    output logic                        commit_pulse,
    output logic [IDX_W-1:0]            commit_group
);

    localparam int unsigned      SEL_W       = NUM_GROUPS * IDX_W;
    localparam logic [IDX_W-1:0] MAX_IDX     = IDX_W'(NUM_GROUPS * ITEMS_PER_GROUP - 1);
    localparam logic [IDX_W-1:0] LAST_ITEM   = IDX_W'(ITEMS_PER_GROUP - 1);
    localparam logic [IDX_W-1:0] LAST_GROUP  = IDX_W'(NUM_GROUPS - 1);
    localparam logic [31:0]      DELAY_LAST  = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0]      PERIOD_LAST = 32'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               dir_prev_q, dir_prev_d;
    logic [31:0]        cnt_q, cnt_d;
    logic [3:0]         prev_q, prev_d;
    logic [3:0]         arm_q, arm_d;
    logic [IDX_W-1:0]   idx_d, grp_d, item_d, cgrp_d;
    logic [SEL_W-1:0]   sel_d;
    logic               pulse_d;

    logic [3:0]         btn_c;
    logic [3:0]         press_c;
    logic               held_c;
    logic [IDX_W-1:0]   cur_sel_c;
    logic               step;
    logic               step_prev;

    // Bit order: 0 prev, 1 next, 2 ok, 3 cancel.
    assign btn_c     = {btn_cancel, btn_ok, btn_next, btn_prev};
    // A button only arms after it has been seen low since reset/enable.
    assign press_c   = btn_c & ~prev_q & arm_q;
    assign held_c    = dir_prev_q ? btn_prev : btn_next;
    assign cur_sel_c = sel_value[cursor_group*IDX_W +: IDX_W];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            dir_prev_q   <= 1'b0;
            cnt_q        <= '0;
            prev_q       <= '0;
            arm_q        <= '0;
            cursor_index <= '0;
            cursor_group <= '0;
            cursor_item  <= '0;
            sel_value    <= GROUP_DEFAULTS;
            commit_pulse <= 1'b0;
            commit_group <= '0;
        end else begin
            state_q      <= state_d;
            dir_prev_q   <= dir_prev_d;
            cnt_q        <= cnt_d;
            prev_q       <= prev_d;
            arm_q        <= arm_d;
            cursor_index <= idx_d;
            cursor_group <= grp_d;
            cursor_item  <= item_d;
            sel_value    <= sel_d;
            commit_pulse <= pulse_d;
            commit_group <= cgrp_d;
        end
    end

    // Next-state: auto-repeat FSM, then step > ok > cancel datapath.
    always_comb begin
        state_d    = state_q;
        dir_prev_d = dir_prev_q;
        cnt_d      = cnt_q;
        prev_d     = btn_c;
        arm_d      = arm_q | ~btn_c;
        idx_d      = cursor_index;
        grp_d      = cursor_group;
        item_d     = cursor_item;
        sel_d      = sel_value;
        pulse_d    = 1'b0;
        cgrp_d     = commit_group;
        step       = 1'b0;
        step_prev  = dir_prev_q;

        case (state_q)
            ST_IDLE: begin
                if (press_c[0]) begin
                    step       = 1'b1;
                    step_prev  = 1'b1;
                    dir_prev_d = 1'b1;
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                end else if (press_c[1]) begin
                    step       = 1'b1;
                    step_prev  = 1'b0;
                    dir_prev_d = 1'b0;
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                end
            end
            ST_HOLD: begin
                if (!held_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DELAY_LAST) begin
                    step    = 1'b1;
                    state_d = ST_REPEAT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_REPEAT: begin
                if (!held_c) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == PERIOD_LAST) begin
                    step  = 1'b1;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (step) begin
            if (step_prev) begin
                if (cursor_item == '0) begin
                    item_d = LAST_ITEM;
                    grp_d  = (cursor_group == '0) ? LAST_GROUP : cursor_group - 1'b1;
                end else begin
                    item_d = cursor_item - 1'b1;
                end
                idx_d = (cursor_index == '0) ? MAX_IDX : cursor_index - 1'b1;
            end else begin
                if (cursor_item == LAST_ITEM) begin
                    item_d = '0;
                    grp_d  = (cursor_group == LAST_GROUP) ? '0 : cursor_group + 1'b1;
                end else begin
                    item_d = cursor_item + 1'b1;
                end
                idx_d = (cursor_index == MAX_IDX) ? '0 : cursor_index + 1'b1;
            end
        end else if (state_q == ST_IDLE && press_c[2]) begin
            if (!(LABEL_ITEM0 && cursor_item == '0)) begin
                sel_d[cursor_group*IDX_W +: IDX_W] = cursor_item;
                pulse_d = 1'b1;
                cgrp_d  = cursor_group;
            end
        end else if (state_q == ST_IDLE && press_c[3]) begin
            // Rebase the flat index onto the committed item without a multiply.
            item_d = cur_sel_c;
            idx_d  = cursor_index - cursor_item + cur_sel_c;
        end

        if (!en) begin
            state_d    = ST_IDLE;
            dir_prev_d = 1'b0;
            cnt_d      = '0;
            prev_d     = '0;
            arm_d      = '0;
            idx_d      = '0;
            grp_d      = '0;
            item_d     = '0;
            sel_d      = GROUP_DEFAULTS;
            pulse_d    = 1'b0;
            cgrp_d     = '0;
        end
    end

endmodule
